// File: rtl/pixel_packer_pkg.sv
// pixel_packer_pkg
// Shared types and constants for the pixel packer:
//   fp / vec3    - Q15.16 fixed point scalar and 3-vector used by the ray unit
//   rgb_t        - 24-bit packed pixel {R, G, B}
//   pix_entry_t  - FIFO entry {tuser, tlast, rgb}
//   BG_COLOUR_DEFAULT, Z_CLAMP_MAX
//   depth_grey() - depth-to-grey shading rule
package pixel_packer_pkg;

  localparam int FP_WIDTH = 32;

  // Same layout as the ray unit's shared fixed-point headers.
  typedef logic signed [FP_WIDTH-1:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic tuser;
    logic tlast;
    rgb_t rgb;
  } pix_entry_t;

  localparam int          PIX_ENTRY_W       = $bits(pix_entry_t);
  localparam logic [23:0] BG_COLOUR_DEFAULT = 24'h202040;
  localparam int          Z_CLAMP_MAX       = 255;

  // Integer part of z (floor, via arithmetic shift), clamped to 0..255,
  // inverted so near surfaces are bright.
  function automatic logic [7:0] depth_grey(input fp z, input int unsigned frac_bits);
    fp          z_int;
    logic [7:0] c;
    z_int = z >>> frac_bits;
    if (z_int < 0) begin
      c = 8'd0;
    end else if (z_int > fp'(Z_CLAMP_MAX)) begin
      c = 8'(Z_CLAMP_MAX);
    end else begin
      c = z_int[7:0];
    end
    return 8'(Z_CLAMP_MAX) - c;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Synchronous FIFO, first-word shown combinationally from the registered
// read pointer. A write while full is accepted if a read happens in the same
// cycle. Storage is not reset; only the pointers are.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    write request / data
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry (undefined when empty)
//   full, empty       status
module pixel_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_accept;
  logic              rd_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pixel_packer.sv
// pixel_packer
// Converts the in-order ray result stream into a depth-shaded RGB AXI4-Stream
// video stream. Tracks the frame/line position of every result, shades it in
// one register stage, buffers it in pixel_fifo and presents the FIFO head on
// the AXIS port. The ray unit cannot stall, so results arriving with a full
// FIFO are dropped and flagged on the sticky overflow output.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in, hit            result strobe and hit flag
//   surface_point            hit point (only .z is used)
//   out_tdata[31:0]          {8'h00, R, G, B}; 0 while out_tvalid is low
//   out_tvalid, out_tready   AXIS handshake
//   out_tuser, out_tlast     start of frame / end of line
//   overflow                 sticky, a result was dropped
//   frame_done               pulse after the last pixel of a frame arrives
// Build option:
//   PIXEL_PACKER_FRAME_STATS_EN adds hit_count[31:0], the number of hits in
//   the most recently completed frame.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int          WIDTH      = 640,
  parameter int          HEIGHT     = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter int          FRAC_BITS  = 16,
  parameter logic [23:0] BG_COLOUR  = BG_COLOUR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        hit,
  input  vec3         surface_point,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        overflow,
  output logic        frame_done
`ifdef PIXEL_PACKER_FRAME_STATS_EN
  ,
  output logic [31:0] hit_count
`endif
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;
  logic          y_last;
  logic          frame_end;
  logic          frame_done_q, frame_done_d;

  logic          sh_valid_q, sh_valid_d;
  pix_entry_t    sh_entry_q, sh_entry_d;
  logic [7:0]    grey;

  logic          overflow_q, overflow_d;
  logic          fifo_wr;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PIX_ENTRY_W-1:0] fifo_rdata;
  pix_entry_t    head;

  logic          unused_xy;
  assign unused_xy = ^{surface_point.x, surface_point.y};

  // Position tracking: every result advances the raster, dropped or not, so
  // a loss never shifts later pixels out of place.
  assign x_last    = (x_q == XW'(WIDTH - 1));
  assign y_last    = (y_q == YW'(HEIGHT - 1));
  assign frame_end = x_last && y_last;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    if (valid_in) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Shade stage
  assign grey = depth_grey(surface_point.z, FRAC_BITS);

  always_comb begin
    sh_valid_d = valid_in;
    sh_entry_d = sh_entry_q;
    if (valid_in) begin
      sh_entry_d.tuser = (x_q == '0) && (y_q == '0);
      sh_entry_d.tlast = x_last;
      sh_entry_d.rgb   = hit ? rgb_t'({grey, grey, grey}) : rgb_t'(BG_COLOUR);
    end
  end

  // FIFO write / drop. A full FIFO still takes the entry if the head leaves
  // in the same cycle.
  assign fifo_pop = !fifo_empty && out_tready;
  assign fifo_wr  = sh_valid_q && (!fifo_full || fifo_pop);

  always_comb begin
    overflow_d = overflow_q;
    if (sh_valid_q && !fifo_wr) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      sh_valid_q   <= 1'b0;
      sh_entry_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      sh_valid_q   <= sh_valid_d;
      sh_entry_q   <= sh_entry_d;
      overflow_q   <= overflow_d;
    end
  end

  pixel_fifo #(
    .DATA_W (PIX_ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (sh_entry_q),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FIFO storage is not reset, so the head is masked while empty to keep the
  // output bus at zero out of reset.
  assign head       = pix_entry_t'(fifo_rdata);
  assign out_tvalid = !fifo_empty;
  assign out_tdata  = fifo_empty ? 32'h0 : {8'h00, head.rgb};
  assign out_tuser  = !fifo_empty && head.tuser;
  assign out_tlast  = !fifo_empty && head.tlast;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

`ifdef PIXEL_PACKER_FRAME_STATS_EN
  // Hits are counted at the input, so dropped pixels still count. The last
  // pixel's own hit is folded into the latched total.
  logic [31:0] hit_acc_q, hit_acc_d;
  logic [31:0] hit_count_q, hit_count_d;

  always_comb begin
    hit_acc_d   = hit_acc_q;
    hit_count_d = hit_count_q;
    if (valid_in) begin
      if (frame_end) begin
        hit_count_d = hit_acc_q + 32'(hit);
        hit_acc_d   = '0;
      end else begin
        hit_acc_d = hit_acc_q + 32'(hit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_acc_q   <= '0;
      hit_count_q <= '0;
    end else begin
      hit_acc_q   <= hit_acc_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Downstream stage of the ray unit: consumes the in-order stream of (hit, surface_point) results, converts each to a 24-bit RGB depth-shaded pixel, tags frame/line position, buffers in a FIFO and emits an AXI4-Stream video stream (tuser = start of frame, tlast = end of line) toward the VDMA. Absorbs output back-pressure, since the ray unit has no stall input; losses are flagged, never silent.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- FIFO_DEPTH, 16, entries; power of two, ≥4
- FRAC_BITS, 16, fractional bits of `fp`
- BG_COLOUR, 24'h202040, RGB for misses
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  result strobe from ray unit (valid_out)
- hit  in  1  ray hit a surface
- surface_point  in  vec3  hit point; only .z used
- out_tdata  out  32  {8'h00, R, G, B}
- out_tvalid  out  1  AXIS valid
- out_tready  in  1  AXIS ready
- out_tuser  out  1  first pixel of frame
- out_tlast  out  1  last pixel of line
- overflow  out  1  sticky: a result was dropped on full FIFO
- frame_done  out  1  one-cycle pulse when last pixel of a frame is accepted at input

## Operation
- Position counters x (0..WIDTH-1), y (0..HEIGHT-1) advance on every valid_in, including dropped results; x wraps to 0 with y+1; at (WIDTH-1, HEIGHT-1) both wrap to 0 and frame_done pulses next cycle.
- Shade stage (registered): z_int = surface_point.z >>> FRAC_BITS (arithmetic); c = clamp(z_int, 0, 255); grey = 255 − c; pixel = hit ? {grey,grey,grey} : BG_COLOUR. tuser = (x==0 && y==0), tlast = (x==WIDTH-1), captured with the pixel.
- FIFO entry = {tuser, tlast, rgb} (26 bits). Write when shade stage valid and (not full, or full with a read in the same cycle). Otherwise drop, set overflow; overflow clears only on rst.
- Output: out_tvalid = FIFO non-empty; head shown combinationally from a registered read pointer; pop on out_tvalid && out_tready.
- Empty FIFO with simultaneous write: data visible next cycle, no bypass.
- Reset mid-frame: FIFO flushed, counters zero, overflow/frame_done zero; next valid_in is treated as pixel (0,0).

## Timing
- Reset values: out_tvalid=0, out_tdata=0, out_tuser=0, out_tlast=0, overflow=0, frame_done=0.
- Latency valid_in → out_tvalid: 2 cycles (shade reg, FIFO write) with empty FIFO.
- Sustained throughput 1 pixel/cycle when out_tready=1.
- AXIS rules: tdata/tuser/tlast stable while tvalid && !tready; tvalid never drops without a handshake (except rst).
- overflow sets the cycle after the dropped write attempt.

## Configuration
- PIXEL_PACKER_FRAME_STATS_EN: defined → adds output hit_count [31:0], counting hits per frame, latched to hit_count on frame_done (including the last pixel), internal counter cleared; reset 0. Undefined → port and logic absent; all other behaviour identical.

## Structure
- Shared package: `rgb_t` (24-bit packed R,G,B), `pix_entry_t` {tuser, tlast, rgb_t}, `BG_COLOUR` default, z clamp constant 255. `fp`/`vec3` come from existing shared headers.
- One sub-module: `pixel_fifo` (synchronous, parameterised width/depth, full/empty, simultaneous read/write on full allowed).

## Test plan
- Single miss after reset, out_tready=1 → out_tdata=32'h00202040 two cycles later, tuser=1, tlast=0.
- Hit with z=5.0 (5<<16) → tdata=32'h00FAFAFA; z=−3.0 → 32'h00FFFFFF; z=300.0 → 32'h00000000.
- WIDTH=4, HEIGHT=2, 8 consecutive valids → tuser on pixel 0 only, tlast on pixels 3 and 7, frame_done one pulse after pixel 7, ninth pixel has tuser=1.
- out_tready=0, 20 valids, FIFO_DEPTH=16 → 16 entries held, overflow=1, then ready=1 → exactly 16 pixels out, in order, tdata stable while stalled.
- rst asserted mid-frame with FIFO half full → out_tvalid=0 next cycle, overflow=0, next pixel carries tuser=1.
- With PIXEL_PACKER_FRAME_STATS_EN, WIDTH=4, HEIGHT=2, 3 hits in frame → hit_count=3 after frame_done; next frame 0 hits → 0.
